// File: rtl/fll_pkg.sv
// rtl/fll_pkg.sv - shared types and saturating helpers for FLL/PLL controllers
package fll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } fll_seq_state_t;

  localparam int CORNER_HI = 0;
  localparam int CORNER_LO = 2;

  // Operands are zero-extended to 64 bits so one helper serves every width up to 64.
  function automatic logic [63:0] sat_sub(input logic [63:0] a, input logic [63:0] b);
    return (a < b) ? 64'd0 : (a - b);
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'd1 << w) - 65'd1;
    return (sum > max) ? 64'(max) : 64'(sum);
  endfunction

endpackage

// File: rtl/fll_sat_bounds.sv
// rtl/fll_sat_bounds.sv - window bounds target-tol / target+tol, clamped to [0, 2^N-1]
module fll_sat_bounds
  import fll_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] target,
  input  logic [N-1:0] tol,
  output logic [N-1:0] lower,
  output logic [N-1:0] upper
);

  assign lower = N'(sat_sub(64'(target), 64'(tol)));
  assign upper = N'(sat_add(64'(target), 64'(tol), N));

endmodule

// File: rtl/fll_lock_seq.sv
// rtl/fll_lock_seq.sv - arms fll_2, steps the coarse band, qualifies and monitors lock
module fll_lock_seq
  import fll_pkg::*;
#(
  parameter int N        = 32,
  parameter int BAND_W   = 3,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk_ref,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [N-1:0]      target,
  input  logic [N-1:0]      tol,
  input  logic [N-1:0]      gate_cfg,
  input  logic [BAND_W-1:0] band_init,
  input  logic              fll_strobe,
  input  logic              fll_locked,
  input  logic [2:0]        fll_corner,
  output logic              fll_reset,
  output logic [N-1:0]      lower_bound,
  output logic [N-1:0]      upper_bound,
  output logic [N-1:0]      gate_time,
  output logic [BAND_W-1:0] band,
  output logic              busy,
  output logic              locked,
  output logic              fail,
  output logic              lost_lock,
  output logic [2:0]        state
);

  fll_seq_state_t    state_q, state_d;
  logic              fll_reset_q, fll_reset_d;
  logic [N-1:0]      lower_q, lower_d, upper_q, upper_d, gate_q, gate_d;
  logic [BAND_W-1:0] band_q, band_d;
  logic              busy_q, busy_d, locked_q, locked_d, fail_q, fail_d, lost_q, lost_d;
  logic              arm_cnt_q, arm_cnt_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic [N-1:0]      lower_calc, upper_calc;
  logic [7:0]        lock_inc, miss_inc;
  logic [15:0]       to_inc;

  fll_sat_bounds #(.N(N)) u_bounds (
    .target (target),
    .tol    (tol),
    .lower  (lower_calc),
    .upper  (upper_calc)
  );

  assign lock_inc = lock_cnt_q + 8'd1;
  assign miss_inc = miss_cnt_q + 8'd1;
  assign to_inc   = to_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    fll_reset_d = fll_reset_q;
    lower_d     = lower_q;
    upper_d     = upper_q;
    gate_d      = gate_q;
    band_d      = band_q;
    arm_cnt_d   = arm_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    to_cnt_d    = to_cnt_q;
    lost_d      = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      fll_reset_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fll_reset_d = 1'b0;
          if (start) begin
            lower_d     = lower_calc;
            upper_d     = upper_calc;
            gate_d      = gate_cfg;
            band_d      = band_init;
            arm_cnt_d   = 1'b0;
            lock_cnt_d  = '0;
            miss_cnt_d  = '0;
            to_cnt_d    = '0;
            fll_reset_d = 1'b1;
            state_d     = ST_ARM;
          end
        end
        ST_ARM: begin
          lock_cnt_d = '0;
          miss_cnt_d = '0;
          to_cnt_d   = '0;
          if (arm_cnt_q) begin
            arm_cnt_d   = 1'b0;
            fll_reset_d = 1'b0;
            state_d     = ST_TRACK;
          end else begin
            arm_cnt_d   = 1'b1;
            fll_reset_d = 1'b1;
          end
        end
        ST_TRACK: begin
          if (fll_strobe) begin
            to_cnt_d = to_inc;
            if (fll_corner[CORNER_HI]) begin
              if (band_q == '0) begin
                state_d = ST_FAIL;
              end else begin
                band_d      = band_q - 1'b1;
                arm_cnt_d   = 1'b0;
                fll_reset_d = 1'b1;
                state_d     = ST_ARM;
              end
            end else if (fll_corner[CORNER_LO]) begin
              if (band_q == '1) begin
                state_d = ST_FAIL;
              end else begin
                band_d      = band_q + 1'b1;
                arm_cnt_d   = 1'b0;
                fll_reset_d = 1'b1;
                state_d     = ST_ARM;
              end
            end else if (fll_locked) begin
              lock_cnt_d = lock_inc;
              if (lock_inc == 8'(LOCK_CNT)) state_d = ST_LOCKED;
            end else begin
              lock_cnt_d = '0;
            end
            // Timeout only fires when no band step or lock decision took this strobe.
            if (state_d == ST_TRACK && to_inc == 16'(TIMEOUT)) state_d = ST_FAIL;
          end
        end
        ST_LOCKED: begin
          if (fll_strobe) begin
            if (fll_locked) begin
              miss_cnt_d = '0;
            end else if (miss_inc == 8'(MISS_MAX)) begin
              lost_d     = 1'b1;
              miss_cnt_d = '0;
              lock_cnt_d = '0;
              to_cnt_d   = '0;
              state_d    = ST_TRACK;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d   = (state_d == ST_ARM) || (state_d == ST_TRACK) || (state_d == ST_LOCKED);
    locked_d = (state_d == ST_LOCKED);
    fail_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fll_reset_q <= 1'b1;
      lower_q     <= '0;
      upper_q     <= '0;
      gate_q      <= '0;
      band_q      <= '0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      lost_q      <= 1'b0;
      arm_cnt_q   <= 1'b0;
      lock_cnt_q  <= '0;
      miss_cnt_q  <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      fll_reset_q <= fll_reset_d;
      lower_q     <= lower_d;
      upper_q     <= upper_d;
      gate_q      <= gate_d;
      band_q      <= band_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      lost_q      <= lost_d;
      arm_cnt_q   <= arm_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign fll_reset   = fll_reset_q;
  assign lower_bound = lower_q;
  assign upper_bound = upper_q;
  assign gate_time   = gate_q;
  assign band        = band_q;
  assign busy        = busy_q;
  assign locked      = locked_q;
  assign fail        = fail_q;
  assign lost_lock   = lost_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fll_lock_seq.sv
// tb/tb_fll_lock_seq.sv - directed bench for fll_lock_seq with a cycle-level reference model
module tb_fll_lock_seq;

  localparam int N  = 8;
  localparam int BW = 3;
  localparam int LC = 4;
  localparam int MM = 2;
  localparam int TO = 8;

  logic          clk_ref = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [N-1:0]  target = '0, tol = '0, gate_cfg = '0;
  logic [BW-1:0] band_init = '0;
  logic          fll_strobe = 1'b0, fll_locked = 1'b0;
  logic [2:0]    fll_corner = '0;
  logic          fll_reset, busy, locked, fail, lost_lock;
  logic [N-1:0]  lower_bound, upper_bound, gate_time;
  logic [BW-1:0] band;
  logic [2:0]    state;

  int errors = 0;
  int checks = 0;

  fll_lock_seq #(.N(N), .BAND_W(BW), .LOCK_CNT(LC), .MISS_MAX(MM), .TIMEOUT(TO)) dut (
    .clk_ref     (clk_ref),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .target      (target),
    .tol         (tol),
    .gate_cfg    (gate_cfg),
    .band_init   (band_init),
    .fll_strobe  (fll_strobe),
    .fll_locked  (fll_locked),
    .fll_corner  (fll_corner),
    .fll_reset   (fll_reset),
    .lower_bound (lower_bound),
    .upper_bound (upper_bound),
    .gate_time   (gate_time),
    .band        (band),
    .busy        (busy),
    .locked      (locked),
    .fail        (fail),
    .lost_lock   (lost_lock),
    .state       (state)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 arming, 2 tracking, 3 locked, 4 failed.
  int m_phase = 0, m_arm_left = 0, m_hits = 0, m_misses = 0, m_strobes = 0;
  int m_lb = 0, m_ub = 0, m_gate = 0, m_band = 0;
  bit m_freset = 1'b1, m_lost = 1'b0;

  always @(posedge clk_ref or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_freset = 1'b1; m_lost = 1'b0;
      m_lb = 0; m_ub = 0; m_gate = 0; m_band = 0;
    end else begin
      m_lost = 1'b0;
      if (stop) begin
        m_phase = 0; m_freset = 1'b0;
      end else if (m_phase == 0) begin
        m_freset = 1'b0;
        if (start) begin
          m_lb = (int'(target) > int'(tol)) ? int'(target) - int'(tol) : 0;
          m_ub = int'(target) + int'(tol);
          if (m_ub > 255) m_ub = 255;
          m_gate = int'(gate_cfg); m_band = int'(band_init);
          m_phase = 1; m_arm_left = 2; m_freset = 1'b1;
        end
      end else if (m_phase == 1) begin
        m_arm_left--;
        if (m_arm_left == 0) begin
          m_phase = 2; m_freset = 1'b0; m_hits = 0; m_misses = 0; m_strobes = 0;
        end
      end else if (m_phase == 2 && fll_strobe) begin
        m_strobes++;
        if (fll_corner[0]) begin
          if (m_band == 0) m_phase = 4;
          else begin m_band--; m_phase = 1; m_arm_left = 2; m_freset = 1'b1; end
        end else if (fll_corner[2]) begin
          if (m_band == 7) m_phase = 4;
          else begin m_band++; m_phase = 1; m_arm_left = 2; m_freset = 1'b1; end
        end else if (fll_locked) begin
          m_hits++;
          if (m_hits == LC) m_phase = 3;
        end else m_hits = 0;
        if (m_phase == 2 && m_strobes == TO) m_phase = 4;
      end else if (m_phase == 3 && fll_strobe) begin
        if (fll_locked) m_misses = 0;
        else begin
          m_misses++;
          if (m_misses == MM) begin
            m_lost = 1'b1; m_phase = 2; m_hits = 0; m_strobes = 0; m_misses = 0;
          end
        end
      end
    end
  end

  always @(negedge clk_ref) begin
    chk("state", int'(state), m_phase);
    chk("fll_reset", int'(fll_reset), int'(m_freset));
    chk("lower_bound", int'(lower_bound), m_lb);
    chk("upper_bound", int'(upper_bound), m_ub);
    chk("gate_time", int'(gate_time), m_gate);
    chk("band", int'(band), m_band);
    chk("busy", int'(busy), int'(m_phase >= 1 && m_phase <= 3));
    chk("locked", int'(locked), int'(m_phase == 3));
    chk("fail", int'(fail), int'(m_phase == 4));
    chk("lost_lock", int'(lost_lock), int'(m_lost));
  end

  task automatic cyc();
    @(negedge clk_ref);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic strobe(input logic lk, input logic [2:0] cor);
    fll_strobe = 1'b1; fll_locked = lk; fll_corner = cor;
    cyc();
    fll_strobe = 1'b0; fll_locked = 1'b0; fll_corner = '0;
  endtask

  task automatic wait_track();
    int n;
    n = 0;
    while (state != 3'd2 && n < 10) begin cyc(); n++; end
    chk("wait_track_timeout", int'(state), 2);
  endtask

  task automatic config_start(input int t, input int tl, input int bi);
    target = N'(t); tol = N'(tl); gate_cfg = 8'd50; band_init = BW'(bi);
    pulse_start();
  endtask

  initial begin
    int hi_cycles;
    reset = 1'b1;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_fll_reset", int'(fll_reset), 1);
    chk("rst_band", int'(band), 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("fll_reset_release", int'(fll_reset), 0);

    // Bounds and the two-cycle arm pulse
    config_start(100, 5, 3);
    chk("lb_95", int'(lower_bound), 95);
    chk("ub_105", int'(upper_bound), 105);
    hi_cycles = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (fll_reset) hi_cycles++;
    end
    chk("fll_reset_width", hi_cycles, 2);
    chk("state_track", int'(state), 2);

    for (int i = 0; i < LC; i++) begin
      chk("not_locked_yet", int'(locked), 0);
      strobe(1'b1, 3'b000);
    end
    chk("locked_after_4", int'(locked), 1);

    // Single miss then hit stays locked; two misses lose lock
    strobe(1'b0, 3'b000); cyc();
    strobe(1'b1, 3'b000); cyc();
    chk("still_locked", int'(state), 3);
    strobe(1'b0, 3'b000); cyc();
    strobe(1'b0, 3'b000);
    chk("lost_lock_pulse", int'(lost_lock), 1);
    chk("lost_to_track", int'(state), 2);
    chk("lost_band_kept", int'(band), 3);
    cyc();
    chk("lost_lock_one_cycle", int'(lost_lock), 0);

    // start outside IDLE ignored; stop with a strobe on the same edge
    pulse_start();
    chk("start_ignored", int'(state), 2);
    stop = 1'b1; fll_strobe = 1'b1; fll_corner = 3'b001;
    cyc();
    stop = 1'b0; fll_strobe = 1'b0; fll_corner = '0;
    chk("stop_idle", int'(state), 0);
    chk("stop_band_held", int'(band), 3);
    chk("stop_lb_held", int'(lower_bound), 95);

    // Band stepping down to failure; strobe during ARM is ignored
    config_start(100, 5, 3);
    strobe(1'b0, 3'b001);
    chk("arm_strobe_ignored", int'(band), 3);
    wait_track();
    strobe(1'b0, 3'b001);
    chk("band_dec", int'(band), 2);
    chk("rearm_reset", int'(fll_reset), 1);
    wait_track();
    strobe(1'b1, 3'b001);
    chk("corner_wins", int'(band), 1);
    wait_track();
    strobe(1'b0, 3'b001);
    wait_track();
    chk("band_zero", int'(band), 0);
    strobe(1'b0, 3'b001);
    chk("fail_at_zero", int'(fail), 1);
    cyc(); cyc();
    chk("fail_held", int'(state), 4);
    pulse_stop();

    // Band stepping up at all-ones fails
    config_start(100, 5, 7);
    wait_track();
    strobe(1'b0, 3'b100);
    chk("fail_at_ones", int'(fail), 1);
    pulse_stop();

    // Saturating bounds
    config_start(3, 10, 0);
    chk("lb_sat_0", int'(lower_bound), 0);
    chk("ub_13", int'(upper_bound), 13);
    pulse_stop();
    config_start(250, 10, 4);
    chk("ub_sat_255", int'(upper_bound), 255);
    chk("lb_240", int'(lower_bound), 240);
    wait_track();

    // Timeout after TO strobes with alternating lock indication
    for (int i = 0; i < TO; i++) begin
      chk("no_early_fail", int'(fail), 0);
      strobe((i % 2) == 0, 3'b000);
      if (i < TO - 1) cyc();
    end
    chk("timeout_fail", int'(state), 4);
    pulse_stop();

    // Asynchronous reset while locked
    config_start(100, 5, 5);
    wait_track();
    for (int i = 0; i < LC; i++) strobe(1'b1, 3'b000);
    chk("relocked", int'(locked), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_fll_reset", int'(fll_reset), 1);
    chk("arst_bounds", int'(lower_bound) + int'(upper_bound) + int'(gate_time), 0);
    chk("arst_band", int'(band), 0);
    chk("arst_status", int'({busy, locked, fail, lost_lock}), 0);
    cyc();
    reset = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
